fifo_param: RTL and testbench

Parametrised synchronous FIFO with a registered status state machine. It is the successor to the 8-deep, single-operation FIFO: data width and depth are configurable, a read and a write can complete in the same cycle, and it adds almost-full/almost-empty flags. It is the generic buffer between producer/consumer blocks in the single-clock domain.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_param_cal.sv | 83 ++++++++
 rtl/fifo_param.sv | 113 +++++++++++
 tb/tb_fifo_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
package fifo_pkg;

    // Registered status state; the encoding is visible on the debug port.
    typedef enum logic [2:0] {
        INIT     = 3'b000,
        NO_OP    = 3'b001,
        WRITE    = 3'b010,
        WR_ERROR = 3'b011,
        READ     = 3'b100,
        RD_ERROR = 3'b101,
        RD_WR    = 3'b110
    } fifo_state_t;

endpackage

// File: rtl/fifo_param_cal.sv
// Combinational next-state / pointer / count calculation for fifo_param.
// Handshake: a request (wr_en or rd_en) is taken when sampled high at a
// rising edge; whether it was accepted is reported by the registered
// ack/err outputs during the following cycle. There is no back-pressure
// other than the err indication.
module fifo_param_cal
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_head,
    input  logic [ADDR_WIDTH-1:0] i_tail,
    input  logic [ADDR_WIDTH:0]   i_count,
    output fifo_state_t           o_state,
    output logic [ADDR_WIDTH-1:0] o_head,
    output logic [ADDR_WIDTH-1:0] o_tail,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_we,
    output logic                  o_re,
    output logic                  o_rd_err
);

    localparam logic [ADDR_WIDTH:0]   C_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic w_full;
    logic w_empty;

    // Decide which requests are accepted and the resulting state, pointers and count.
    always_comb begin
        w_full   = (i_count == C_DEPTH);
        w_empty  = (i_count == '0);
        o_state  = NO_OP;
        o_we     = 1'b0;
        o_re     = 1'b0;
        case ({i_wr_en, i_rd_en})
            2'b10: begin
                if (w_full) begin
                    o_state = WR_ERROR;
                end else begin
                    o_state = WRITE;
                    o_we    = 1'b1;
                end
            end
            2'b01: begin
                if (w_empty) begin
                    o_state = RD_ERROR;
                end else begin
                    o_state = READ;
                    o_re    = 1'b1;
                end
            end
            2'b11: begin
                // Read while empty is rejected (no fall-through); when full the
                // read frees the slot the write fills, so both are accepted.
                o_we = 1'b1;
                if (w_empty) begin
                    o_state = WRITE;
                end else begin
                    o_state = RD_WR;
                    o_re    = 1'b1;
                end
            end
            default: o_state = NO_OP;
        endcase

        // Any read request against an empty FIFO is an error, alone or paired.
        o_rd_err = i_rd_en && w_empty;

        o_head = o_re ? (i_head + C_PTR_ONE) : i_head;
        o_tail = o_we ? (i_tail + C_PTR_ONE) : i_tail;

        case ({o_we, o_re})
            2'b10:   o_count = i_count + C_CNT_ONE;
            2'b01:   o_count = i_count - C_CNT_ONE;
            default: o_count = i_count;
        endcase
    end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with simultaneous read/write, registered
// status state and almost-full / almost-empty flags.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output fifo_state_t           dbg_state,
    output logic [ADDR_WIDTH-1:0] dbg_head,
    output logic [ADDR_WIDTH-1:0] dbg_tail
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] C_AF    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] C_AE    = AE_LEVEL[ADDR_WIDTH:0];

    fifo_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_head;
    logic [ADDR_WIDTH-1:0] r_tail;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_rd_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    fifo_state_t           w_state;
    logic [ADDR_WIDTH-1:0] w_head;
    logic [ADDR_WIDTH-1:0] w_tail;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_we;
    logic                  w_re;
    logic                  w_rd_err;

    fifo_param_cal #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cal (
        .i_wr_en  (wr_en),
        .i_rd_en  (rd_en),
        .i_head   (r_head),
        .i_tail   (r_tail),
        .i_count  (r_count),
        .o_state  (w_state),
        .o_head   (w_head),
        .o_tail   (w_tail),
        .o_count  (w_count),
        .o_we     (w_we),
        .o_re     (w_re),
        .o_rd_err (w_rd_err)
    );

    // State, pointers, count, read data and rd_err; cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= INIT;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_rd_err <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_head   <= w_head;
            r_tail   <= w_tail;
            r_count  <= w_count;
            r_rd_err <= w_rd_err;
            // Non-blocking read sees the pre-edge word even when the same
            // slot is overwritten in this edge (simultaneous op while full).
            if (w_re) begin
                r_dout <= r_mem[r_head];
            end
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_tail] <= din;
        end
    end

    assign dout         = r_dout;
    assign data_count   = r_count;
    assign full         = (r_count == C_DEPTH);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= C_AF);
    assign almost_empty = (r_count <= C_AE);
    assign wr_ack       = (r_state == WRITE) || (r_state == RD_WR);
    assign wr_err       = (r_state == WR_ERROR);
    assign rd_ack       = (r_state == READ) || (r_state == RD_WR);
    assign rd_err       = r_rd_err;
    assign dbg_state    = r_state;
    assign dbg_head     = r_head;
    assign dbg_tail     = r_tail;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param (8-bit x 8 deep): table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_fifo_param;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic [AW:0]   data_count;
    logic          full, empty, almost_full, almost_empty;
    logic          wr_ack, wr_err, rd_ack, rd_err;
    fifo_state_t   dbg_state;
    logic [AW-1:0] dbg_head, dbg_tail;

    fifo_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .data_count   (data_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err),
        .dbg_state    (dbg_state),
        .dbg_head     (dbg_head),
        .dbg_tail     (dbg_tail)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL timeout: sim time %0t reached without finishing", $time);
        $fatal(1, "timeout");
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: contents as a queue, plus last-cycle outcome.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_dout;
    logic          m_wa, m_we, m_ra, m_re;
    int            m_head, m_tail;
    fifo_state_t   m_state;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_dout  = '0;
        m_wa    = 1'b0;
        m_we    = 1'b0;
        m_ra    = 1'b0;
        m_re    = 1'b0;
        m_head  = 0;
        m_tail  = 0;
        m_state = INIT;
    endtask

    // Apply one sampled request to the model.
    task automatic model_step(input logic w, input logic r, input logic [DW-1:0] d);
        int  cnt;
        logic wok, rok;
        cnt = exp_q.size();
        rok = r && (cnt > 0);
        wok = w && ((cnt < DEPTH) || rok);
        if (rok) begin
            m_dout = exp_q.pop_front();
            m_head = (m_head + 1) % DEPTH;
        end
        if (wok) begin
            exp_q.push_back(d);
            m_tail = (m_tail + 1) % DEPTH;
        end
        m_wa = wok;
        m_we = w && !wok;
        m_ra = rok;
        m_re = r && !rok;
        if (wok && rok)      m_state = RD_WR;
        else if (wok)        m_state = WRITE;
        else if (w)          m_state = WR_ERROR;
        else if (rok)        m_state = READ;
        else if (r)          m_state = RD_ERROR;
        else                 m_state = NO_OP;
    endtask

    task automatic check_model();
        int cnt;
        cnt = exp_q.size();
        chk("count",        32'(data_count),   32'(cnt));
        chk("full",         32'(full),         32'(cnt == DEPTH));
        chk("empty",        32'(empty),        32'(cnt == 0));
        chk("almost_full",  32'(almost_full),  32'(cnt >= DEPTH - 1));
        chk("almost_empty", 32'(almost_empty), 32'(cnt <= 1));
        chk("dout",         32'(dout),         32'(m_dout));
        chk("wr_ack",       32'(wr_ack),       32'(m_wa));
        chk("wr_err",       32'(wr_err),       32'(m_we));
        chk("rd_ack",       32'(rd_ack),       32'(m_ra));
        chk("rd_err",       32'(rd_err),       32'(m_re));
        chk("state",        32'(dbg_state),    32'(m_state));
        chk("head",         32'(dbg_head),     32'(m_head));
        chk("tail",         32'(dbg_tail),     32'(m_tail));
    endtask

    // Driver: present a request, clock it in, check one step after the edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        model_step(w, r, d);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        reset_n = 1'b0;
        #2;
        model_reset();
        check_model();
        @(posedge clk);
        #1;
        check_model();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] d;
        logic          wa;
        logic          we;
        logic          ra;
        logic          re;
        logic [AW:0]   cnt;
        logic [DW-1:0] dq;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // Vector table: fill to full, overflow, drain, underflow.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 1'b0, 8'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 4'(i + 1), 8'h00};
        tbl[8] = '{1'b1, 1'b0, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 8'h00};
        for (int j = 0; j < 8; j++)
            tbl[9 + j] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'(7 - j), 8'(j + 1)};
        tbl[17] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h08};

        #3;
        do_reset();

        for (int k = 0; k < 18; k++) begin
            step(tbl[k].wr, tbl[k].rd, tbl[k].d);
            chk("tbl_wr_ack", 32'(wr_ack),      32'(tbl[k].wa));
            chk("tbl_wr_err", 32'(wr_err),      32'(tbl[k].we));
            chk("tbl_rd_ack", 32'(rd_ack),      32'(tbl[k].ra));
            chk("tbl_rd_err", 32'(rd_err),      32'(tbl[k].re));
            chk("tbl_count",  32'(data_count),  32'(tbl[k].cnt));
            chk("tbl_dout",   32'(dout),        32'(tbl[k].dq));
            chk("tbl_full",   32'(full),        32'(tbl[k].cnt == 4'd8));
            chk("tbl_af",     32'(almost_full), 32'(tbl[k].cnt >= 4'd7));
        end

        // Reset in the middle of a write burst with three words stored.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        chk("pre_rst_count", 32'(data_count), 32'd3);
        wr_en = 1'b1;
        din   = 8'h77;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        check_model();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        reset_n = 1'b1;

        // Simultaneous read+write on empty: write taken, read rejected.
        step(1'b1, 1'b1, 8'hAA);
        chk("both_empty_wr_ack", 32'(wr_ack), 32'd1);
        chk("both_empty_rd_err", 32'(rd_err), 32'd1);
        chk("both_empty_count",  32'(data_count), 32'd1);
        step(1'b0, 1'b1, 8'h00);
        chk("both_empty_data", 32'(dout), 32'hAA);

        // Simultaneous read+write on full.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i + 1));
        step(1'b1, 1'b1, 8'h55);
        chk("both_full_dout",   32'(dout), 32'h01);
        chk("both_full_wr_ack", 32'(wr_ack), 32'd1);
        chk("both_full_rd_ack", 32'(rd_ack), 32'd1);
        chk("both_full_count",  32'(data_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("both_full_drain", 32'(dout), 32'(i == 7 ? 8'h55 : 8'(i + 2)));
        end

        // Wrap: write 6, read 6, twice.
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h10 * rep + i));
            for (int i = 0; i < 6; i++) begin
                step(1'b0, 1'b1, 8'h00);
                chk("wrap_data", 32'(dout), 32'(8'(8'h10 * rep + i)));
            end
        end
        chk("wrap_head",  32'(dbg_head), 32'd4);
        chk("wrap_tail",  32'(dbg_tail), 32'd4);
        chk("wrap_count", 32'(data_count), 32'd0);

        // Random traffic with varying write/read bias.
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            int wp;
            wp = (ph == 0) ? 80 : (ph == 2) ? 20 : 50;
            for (int c = 0; c < 400; c++) begin
                logic w, r;
                w = ($urandom_range(99) < wp);
                r = ($urandom_range(99) < (100 - wp));
                step(w, r, 8'($urandom_range(255)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
